// File: rtl/pwm_capture_pkg.sv
// Shared constants and types for the PWM capture core: register map,
// STATUS field offsets and the per-channel measurement state.
package pwm_capture_pkg;

    localparam logic [4:0] REG_CTRL        = 5'd0;
    localparam logic [4:0] REG_STATUS      = 5'd1;
    localparam logic [4:0] REG_PERIOD_BASE = 5'd2;

    localparam int VALID_LSB = 0;
    localparam int OVF_LSB   = 8;
    localparam int LVL_LSB   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } cap_state_t;

endpackage

// File: rtl/pwm_capture_chan.sv
// One capture channel: 2-FF synchroniser, edge history, period/high-time
// measurement FSM, saturating counter and result registers.
module pwm_capture_chan
    import pwm_capture_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         pin,
    output logic         capture,
    output logic         ovf,
    output logic         level,
    output logic [W-1:0] period,
    output logic [W-1:0] high,
    output cap_state_t   state
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic         sync1;
    logic         sync2;
    logic         hist;
    logic         rise;
    logic         fall;
    logic         sat;
    logic [W-1:0] cnt;
    logic [W-1:0] hi_tmp;
    cap_state_t   state_next;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    // Both edges see the same pipeline delay, so durations are exact.
    assign rise  = sync2 & ~hist;
    assign fall  = ~sync2 & hist;
    assign level = sync2;
    assign sat   = (cnt == CNT_MAX);

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        ovf        = 1'b0;
        unique case (state)
            IDLE: begin
                if (en && rise) state_next = HIGH;
            end
            HIGH: begin
                if (!en) begin
                    state_next = IDLE;
                end else if (sat) begin
                    state_next = IDLE;
                    ovf        = 1'b1;
                end else if (fall) begin
                    state_next = LOW;
                end
            end
            LOW: begin
                if (!en) begin
                    state_next = IDLE;
                end else if (sat) begin
                    state_next = IDLE;
                    ovf        = 1'b1;
                end else if (rise) begin
                    state_next = HIGH;
                    capture    = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt    <= '0;
            hi_tmp <= '0;
            period <= '0;
            high   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (state_next == HIGH) cnt <= W'(1);
                end
                HIGH: begin
                    cnt <= cnt + W'(1);
                    if (state_next == LOW) hi_tmp <= cnt;
                end
                LOW: begin
                    if (capture) begin
                        period <= cnt;
                        high   <= hi_tmp;
                        cnt    <= W'(1);
                    end else begin
                        cnt <= cnt + W'(1);
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: rtl/pwm_capture_core.sv
// Multi-channel PWM measurement core: CTRL enables, STATUS flags with
// write-1-to-clear, and the combinational register read mux.
module pwm_capture_core
    import pwm_capture_pkg::*;
#(
    parameter int N = 6,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cs,
    input  logic         read,
    input  logic         write,
    input  logic [4:0]   reg_addr,
    input  logic [31:0]  wr_data,
    output logic [31:0]  rd_data,
    input  logic [N-1:0] pwm_in
);

    logic [N-1:0]        ctrl;
    logic [N-1:0]        valid;
    logic [N-1:0]        ovf_flag;
    logic [N-1:0]        capture;
    logic [N-1:0]        ovf_hit;
    logic [N-1:0]        level;
    logic [N-1:0][W-1:0] period;
    logic [N-1:0][W-1:0] high;
    logic [N-1:0][1:0]   chan_state;
    logic                wr_ctrl;
    logic                wr_status;
    logic                unused_bits;

    assign wr_ctrl     = cs & write & (reg_addr == REG_CTRL);
    assign wr_status   = cs & write & (reg_addr == REG_STATUS);
    assign unused_bits = ^{read, wr_data, chan_state};

    for (genvar i = 0; i < N; i++) begin : gen_chan
        pwm_capture_chan #(.W(W)) u_chan (
            .clk     (clk),
            .reset   (reset),
            .en      (ctrl[i]),
            .pin     (pwm_in[i]),
            .capture (capture[i]),
            .ovf     (ovf_hit[i]),
            .level   (level[i]),
            .period  (period[i]),
            .high    (high[i]),
            .state   (chan_state[i])
        );
    end

    // A capture or overflow in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl     <= '0;
            valid    <= '0;
            ovf_flag <= '0;
        end else begin
            if (wr_ctrl) ctrl <= wr_data[N-1:0];
            valid    <= (wr_status ? (valid & ~wr_data[VALID_LSB +: N]) : valid) | capture;
            ovf_flag <= (wr_status ? (ovf_flag & ~wr_data[OVF_LSB +: N]) : ovf_flag) | ovf_hit;
        end
    end

    always_comb begin
        rd_data = '0;
        if (reg_addr == REG_CTRL) begin
            rd_data[N-1:0] = ctrl;
        end else if (reg_addr == REG_STATUS) begin
            rd_data[VALID_LSB +: N] = valid;
            rd_data[OVF_LSB +: N]   = ovf_flag;
            rd_data[LVL_LSB +: N]   = level;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (reg_addr == REG_PERIOD_BASE + 5'(2 * i))     rd_data[W-1:0] = period[i];
                if (reg_addr == REG_PERIOD_BASE + 5'(2 * i + 1)) rd_data[W-1:0] = high[i];
            end
        end
    end

endmodule
